// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider (div_iter).
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q   = '1;
  localparam logic [DIV_XLEN-1:0] OVF_DIVIDEND = {1'b1, {(DIV_XLEN-1){1'b0}}};

  function automatic logic isSignedOp(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo}, trial-subtract, select.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shRem;
  logic [XLEN:0] diff;
  logic          nonNeg;

  // The partial remainder stays below the divisor, so the shifted value is
  // under 2*divisor and the top bit of an XLEN+1-bit difference is its sign.
  assign shRem  = {rem_i, quo_i[XLEN-1]};
  assign diff   = shRem - {1'b0, dvsr_i};
  assign nonNeg = ~diff[XLEN];

  assign rem_o = nonNeg ? diff[XLEN-1:0] : shRem[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], nonNeg};

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero and signed overflow skip CALC.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIV_ZERO_FAST_EN
  localparam bit FastExc = 1'b1;
`else
  localparam bit FastExc = 1'b0;
`endif

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic            negA_q, negA_d;
  logic            negB_q, negB_d;
  logic            divZero_q, divZero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dividendOrig_q, dividendOrig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  div_op_e         opIn;
  logic            signedIn;
  logic            excIn;
  logic [XLEN-1:0] stepRem;
  logic [XLEN-1:0] stepQuo;
  logic [XLEN-1:0] quoFix;
  logic [XLEN-1:0] remFix;
  logic [XLEN-1:0] fixResult;

  assign opIn     = div_op_e'(op);
  assign signedIn = isSignedOp(opIn);
  assign excIn    = (divisor == '0) ||
                    (signedIn && (dividend == MinNeg) && (divisor == '1));

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (stepRem),
    .quo_o  (stepQuo)
  );

  // Exceptional cases override the datapath so both builds return identical values.
  always_comb begin
    quoFix = (negA_q ^ negB_q) ? -quo_q : quo_q;
    remFix = negA_q ? -rem_q : rem_q;
    if (divZero_q) begin
      quoFix = '1;
      remFix = dividendOrig_q;
    end else if (ovf_q) begin
      quoFix = MinNeg;
      remFix = '0;
    end
    fixResult = ((op_q == OP_REM) || (op_q == OP_REMU)) ? remFix : quoFix;
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    negA_d         = negA_q;
    negB_d         = negB_q;
    divZero_d      = divZero_q;
    ovf_d          = ovf_q;
    dvsr_d         = dvsr_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    dividendOrig_d = dividendOrig_q;
    cnt_d          = cnt_q;
    result_d       = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d           = opIn;
            negA_d         = signedIn & dividend[XLEN-1];
            negB_d         = signedIn & divisor[XLEN-1];
            quo_d          = (signedIn && dividend[XLEN-1]) ? -dividend : dividend;
            dvsr_d         = (signedIn && divisor[XLEN-1]) ? -divisor : divisor;
            rem_d          = '0;
            cnt_d          = '0;
            dividendOrig_d = dividend;
            divZero_d      = (divisor == '0);
            ovf_d          = excIn && (divisor != '0);
            state_d        = (FastExc && excIn) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = fixResult;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= OP_DIV;
      negA_q         <= 1'b0;
      negB_q         <= 1'b0;
      divZero_q      <= 1'b0;
      ovf_q          <= 1'b0;
      dvsr_q         <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dividendOrig_q <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      negA_q         <= negA_d;
      negB_q         <= negB_d;
      divZero_q      <= divZero_d;
      ovf_q          <= ovf_d;
      dvsr_q         <= dvsr_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      dividendOrig_q <= dividendOrig_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Table-driven, scoreboarded bench for div_iter, plus flush/reset/back-to-back sequences.
module tb_div_iter;
  import div_pkg::*;

  localparam int XLEN    = DIV_XLEN;
  localparam int SlowLat = XLEN + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ExcLat = 2;
`else
  localparam int ExcLat = SlowLat;
`endif

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] sbQ[$];
  logic [XLEN-1:0] lastResult;
  vec_t            vecs[$];

  always #5 clk = ~clk;

  div_iter #(.XLEN(XLEN), .CNT_W(DIV_CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_done", XLEN'(done), '0);
      end else begin
        lastResult = sbQ.pop_front();
        checkOutput("result", result, lastResult);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [1:0] o, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                               input int glitchAt, input bit restartInDone);
    int cycles;
    bit exc;
    int expLat;
    exc    = (b == '0) || (((o == 2'b00) || (o == 2'b10)) &&
             (a == OVF_DIVIDEND) && (b == DIV_ZERO_Q));
    expLat = exc ? ExcLat : SlowLat;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    sbQ.push_back(exp);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cycles == 1) checkOutput("busy_after_accept", XLEN'(busy), XLEN'(1));
      start = (cycles == glitchAt);
      if (start) begin
        op       = ~o;
        dividend = ~a;
        divisor  = b + 1;
      end
    end while ((done !== 1'b1) && (cycles < 200));
    start = 1'b0;
    if (done !== 1'b1) begin
      checkOutput("done_timeout", XLEN'(done), XLEN'(1));
      if (sbQ.size() != 0) void'(sbQ.pop_back());
    end else begin
      checkOutput("latency", XLEN'(cycles), XLEN'(expLat));
    end
    if (restartInDone) begin
      start    = 1'b1;
      op       = 2'b01;
      dividend = 32'd9;
      divisor  = 32'd4;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_one_cycle", XLEN'(done), '0);
    if (restartInDone) checkOutput("start_in_done_ignored", XLEN'(busy), '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawDone;
    vecs.push_back('{2'b01, 32'd100,        32'd7,        32'd14});
    vecs.push_back('{2'b11, 32'd100,        32'd7,        32'd2});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF});
    vecs.push_back('{2'b01, 32'd5,          32'd0,        32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0005,  32'd0,        32'h8000_0005});
    vecs.push_back('{2'b00, 32'd5,          32'd0,        32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'd7,          32'd0,        32'd7});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,        32'hC000_0000});
    vecs.push_back('{2'b00, 32'hFFFF_FFF8,  32'd3,        32'hFFFF_FFFE});
    vecs.push_back('{2'b10, 32'hFFFF_FFF8,  32'd3,        32'hFFFF_FFFE});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'h10,       32'hF});
    vecs.push_back('{2'b01, 32'd1000000,    32'd1000,     32'd1000});
    vecs.push_back('{2'b11, 32'd1000003,    32'd1000,     32'd3});
    vecs.push_back('{2'b00, 32'd0,          32'hFFFF_FFFB, 32'd0});

    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", XLEN'(busy), '0);
    checkOutput("reset_done", XLEN'(done), '0);
    checkOutput("reset_result", result, '0);
    lastResult = '0;
    rst = 1'b0;

    // Vector 0 also pulses start mid-operation, which must be ignored.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 5 : 0, 1'b0);
    end

    $display("[TB] flush during CALC");
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", XLEN'(busy), '0);
    checkOutput("flush_done", XLEN'(done), '0);
    checkOutput("flush_result", result, lastResult);
    applyStimulus(2'b01, 32'd100, 32'd7, 32'd14, 0, 1'b0);

    $display("[TB] flush with simultaneous start");
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_beats_start", XLEN'(busy), '0);

    $display("[TB] reset during CALC");
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd100000;
    divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", XLEN'(busy), '0);
    checkOutput("midreset_done", XLEN'(done), '0);
    checkOutput("midreset_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", XLEN'(sawDone), '0);

    $display("[TB] start in DONE cycle");
    applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 0, 1'b1);
    repeat (40) @(negedge clk);

    checkOutput("scoreboard_empty", XLEN'(sbQ.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
